// File: rtl/flp_dot_acc.sv
// Dot-product accumulator: folds a stream of (a,b) pairs into a running sum through a
// combinational fused multiply-add, and presents the sum and beat count on the last beat.
module flp_dot_acc #(
  parameter int EWIDTH  = 8,
  parameter int SWIDTH  = 23,
  parameter int RSWIDTH = 23,
  parameter int CNTW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [EWIDTH+SWIDTH:0]   i_a,
  input  logic [EWIDTH+SWIDTH:0]   i_b,
  input  logic                     i_last,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [EWIDTH+SWIDTH:0]   o_result,
  output logic [CNTW-1:0]          o_count,
  output logic                     o_rvalid,
  input  logic                     i_rready
);

  localparam int W   = 1 + EWIDTH + SWIDTH;
  localparam int RW  = 1 + EWIDTH + RSWIDTH;
  localparam int MW  = SWIDTH + 1;
  localparam int PW  = 2 * MW;
  localparam int XW  = PW + 4;
  localparam int EXW = EWIDTH + 4;
  localparam logic signed [EXW-1:0] BIAS_X = EXW'((1 << (EWIDTH - 1)) - 1);
  localparam logic signed [EXW-1:0] EMAX_X = EXW'((1 << EWIDTH) - 1);
  localparam logic signed [EXW-1:0] XW_X   = EXW'(XW);
  localparam logic [EWIDTH-1:0]     EONES  = '1;

  typedef enum logic [0:0] {ACC = 1'b0, DONE = 1'b1} state_t;

  function automatic logic [EXW-1:0] lzc(input logic [XW-1:0] x);
    logic [EXW-1:0] n;
    logic           found;
    n     = '0;
    found = 1'b0;
    for (int i = XW - 1; i >= 0; i--) begin
      if (found) n = n;
      else if (x[i]) found = 1'b1;
      else n = n + EXW'(1);
    end
    return n;
  endfunction

  // Right shift that folds every bit shifted out into the LSB as a sticky bit.
  function automatic logic [XW-1:0] shr_sticky(input logic [XW-1:0] x, input logic signed [EXW-1:0] d);
    logic [XW-1:0] r;
    logic          s;
    if (d >= XW_X) begin
      r = '0;
      s = |x;
    end else begin
      r = x >> d;
      s = |(x & ~({XW{1'b1}} << d));
    end
    return {r[XW-1:1], r[0] | s};
  endfunction

  // a*b+c with one rounding (nearest-even); subnormal inputs and outputs flush to zero.
  function automatic logic [W-1:0] flp_mac(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] c);
    logic                    sa, sb, sc, sp, rsign, g, st, rup;
    logic [EWIDTH-1:0]       ea, eb, ec;
    logic [SWIDTH-1:0]       fa, fb, fc, frac;
    logic                    za, zb, zc, ia, ib, ic, na, nb, nc;
    logic [PW-1:0]           prod;
    logic signed [EXW-1:0]   ep, ecs, ebig, er;
    logic [EXW-1:0]          lz;
    logic [XW-1:0]           xp, xc, pa, ca, mag, nrm;
    logic [MW:0]             rman;
    logic [W-1:0]            res;
    sa = a[W-1]; ea = a[W-2:SWIDTH]; fa = a[SWIDTH-1:0];
    sb = b[W-1]; eb = b[W-2:SWIDTH]; fb = b[SWIDTH-1:0];
    sc = c[W-1]; ec = c[W-2:SWIDTH]; fc = c[SWIDTH-1:0];
    za = (ea == '0); ia = (ea == EONES) && (fa == '0); na = (ea == EONES) && (fa != '0);
    zb = (eb == '0); ib = (eb == EONES) && (fb == '0); nb = (eb == EONES) && (fb != '0);
    zc = (ec == '0); ic = (ec == EONES) && (fc == '0); nc = (ec == EONES) && (fc != '0);
    sp = sa ^ sb;

    prod = PW'({1'b1, fa}) * PW'({1'b1, fb});
    ep   = EXW'(ea) + EXW'(eb) - BIAS_X;
    xp   = {1'b0, prod, 3'b000};
    if (zc) begin
      xc  = '0;
      ecs = ep;
    end else begin
      xc  = {2'b00, 1'b1, fc, {SWIDTH{1'b0}}, 3'b000};
      ecs = EXW'(ec);
    end

    if (ep >= ecs) begin
      ebig = ep;
      pa   = xp;
      ca   = shr_sticky(xc, ep - ecs);
    end else begin
      ebig = ecs;
      pa   = shr_sticky(xp, ecs - ep);
      ca   = xc;
    end

    if (sp == sc) begin
      mag   = pa + ca;
      rsign = sp;
    end else if (pa >= ca) begin
      mag   = pa - ca;
      rsign = sp;
    end else begin
      mag   = ca - pa;
      rsign = sc;
    end

    lz   = lzc(mag);
    nrm  = mag << lz;
    er   = ebig + EXW'(2) - lz;
    rman = {1'b0, nrm[XW-1 -: MW]};
    g    = nrm[XW-1-MW];
    st   = |nrm[XW-2-MW:0];
    rup  = g & (st | nrm[XW-MW]);
    rman = rman + {{MW{1'b0}}, rup};
    er   = er + EXW'(rman[MW]);
    frac = rman[SWIDTH-1:0];

    if (mag == '0) res = '0;
    else if (er >= EMAX_X) res = {rsign, EONES, {SWIDTH{1'b0}}};
    else if (er <= EXW'(0)) res = {rsign, {(W-1){1'b0}}};
    else res = {rsign, er[EWIDTH-1:0], frac};

    if (na || nb || nc || (ia && zb) || (ib && za) || ((ia || ib) && ic && (sp != sc)))
      res = {1'b0, EONES, 1'b1, {(SWIDTH-1){1'b0}}};
    else if (ia || ib) res = {sp, EONES, {SWIDTH{1'b0}}};
    else if (ic) res = {sc, EONES, {SWIDTH{1'b0}}};
    else if (za || zb) res = zc ? {sp & sc, {(W-1){1'b0}}} : c;
    else res = res;
    return res;
  endfunction

  state_t          state_r, state_nxt;
  logic [W-1:0]    acc_r, acc_nxt, res_nxt;
  logic [CNTW-1:0] cnt_r, cnt_nxt, cnt_inc_s, count_nxt;
  logic [RW-1:0]   mac_s;
  logic            accept_s, rvalid_nxt, ready_nxt;

  assign mac_s     = flp_mac(i_a, i_b, acc_r);
  assign accept_s  = i_valid && o_ready;
  assign cnt_inc_s = (cnt_r == '1) ? cnt_r : cnt_r + CNTW'(1);

  // Next-state and next-output decode for the ACC/DONE controller.
  always_comb begin
    state_nxt  = state_r;
    acc_nxt    = acc_r;
    cnt_nxt    = cnt_r;
    res_nxt    = o_result;
    count_nxt  = o_count;
    rvalid_nxt = o_rvalid;
    case (state_r)
      ACC: begin
        if (accept_s && i_last) begin
          res_nxt    = mac_s;
          count_nxt  = cnt_inc_s;
          acc_nxt    = '0;
          cnt_nxt    = '0;
          rvalid_nxt = 1'b1;
          state_nxt  = DONE;
        end else if (accept_s) begin
          acc_nxt = mac_s;
          cnt_nxt = cnt_inc_s;
        end else begin
          state_nxt = ACC;
        end
      end
      DONE: begin
        if (i_rready) begin
          rvalid_nxt = 1'b0;
          state_nxt  = ACC;
        end else begin
          state_nxt = DONE;
        end
      end
      default: begin
        rvalid_nxt = 1'b0;
        state_nxt  = ACC;
      end
    endcase
    ready_nxt = (state_nxt == ACC);
  end

  // State, accumulator and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ACC;
      acc_r    <= '0;
      cnt_r    <= '0;
      o_result <= '0;
      o_count  <= '0;
      o_rvalid <= 1'b0;
      o_ready  <= 1'b1;
    end else begin
      state_r  <= state_nxt;
      acc_r    <= acc_nxt;
      cnt_r    <= cnt_nxt;
      o_result <= res_nxt;
      o_count  <= count_nxt;
      o_rvalid <= rvalid_nxt;
      o_ready  <= ready_nxt;
    end
  end

endmodule
